mem_lsu: RTL and testbench

Load/store unit sitting between the pipeline's memory stage and a handshaked data memory. It issues word, half and byte accesses on a request/grant/response bus, stalls the pipeline until each access completes, and extends loaded data to 32 bits. It presents the same `ls_ctrl` encoding and little-endian lane placement as the single-cycle data memory, so the memory stage can switch to it without changing its control.

---
 rtl/lsu_pkg.sv | 26 ++
 rtl/lsu_lane_align.sv | 63 ++++++
 rtl/mem_lsu.sv | 137 +++++++++++++
 tb/tb_mem_lsu.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access-size encoding, FSM states, byte-enable bases.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lsu_pkg;

  // Same encoding as the single-cycle data memory; stores treat 10 and 11 alike.
  typedef enum logic [1:0] {
    LS_WORD  = 2'b00,
    LS_HALF  = 2'b01,
    LS_BYTE  = 2'b10,
    LS_BYTEU = 2'b11
  } ls_ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10,
    ST_DONE = 2'b11
  } lsu_state_e;

  // Byte-enable patterns for lane 0; shifted by the low address bits.
  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_BYTE = 4'b0001;

endpackage

// File: rtl/lsu_lane_align.sv
// Lane steering: byte enables + replicated store data (store side), lane extract + extension (load side).
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
// Ports: i_st_addr/i_st_ctrl/i_wdata -> o_be/o_wdata ; i_ld_addr/i_ld_ctrl/i_rdata -> o_rdata.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_st_addr,
  input  ls_ctrl_e    i_st_ctrl,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_ld_addr,
  input  ls_ctrl_e    i_ld_ctrl,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  // Store side. Word accesses ignore a[1:0]; half accesses only look at a[1].
  always_comb begin
    o_be    = BE_WORD;
    o_wdata = i_wdata;
    case (i_st_ctrl)
      LS_WORD: begin
        o_be    = BE_WORD;
        o_wdata = i_wdata;
      end
      LS_HALF: begin
        o_be    = BE_HALF << {i_st_addr[1], 1'b0};
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        o_be    = BE_BYTE << i_st_addr;
        o_wdata = {4{i_wdata[7:0]}};
      end
    endcase
  end

  // Load side lane selection (little-endian).
  always_comb begin
    w_half = i_ld_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_ld_addr)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
  end

  always_comb begin
    o_rdata = i_rdata;
    case (i_ld_ctrl)
      LS_WORD:  o_rdata = i_rdata;
      LS_HALF:  o_rdata = {{16{w_half[15]}}, w_half};
      LS_BYTE:  o_rdata = {{24{w_byte[7]}}, w_byte};
      default:  o_rdata = {24'h0, w_byte};
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: memory-stage access -> req/gnt/rvalid data-memory bus, with load extension.
// Latency: load 3 stall cycles, store 2, +1 per gnt or rvalid wait cycle; misaligned trap (LSU_MISALIGN_EN) 1.
// Backpressure: holds mem_* stable in REQ until mem_gnt; stall_o freezes the pipeline until DONE.
// Ports: pipeline side memread_m/memwrite_m/ls_ctrl_m/addr_m/wdata_m -> stall_o/rdata_o/misalign_o;
//        memory side mem_req/mem_we/mem_addr/mem_be/mem_wdata <- mem_gnt/mem_rvalid/mem_rdata.
// Build option: define LSU_MISALIGN_EN to trap misaligned word/half accesses instead of truncating a[1:0].
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memread_m,
  input  logic              memwrite_m,
  input  logic [1:0]        ls_ctrl_m,
  input  logic [ADDR_W-1:0] addr_m,
  input  logic [31:0]       wdata_m,
  output logic              stall_o,
  output logic [31:0]       rdata_o,
  output logic              misalign_o,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        r_state;
  logic [ADDR_W-1:0] r_addr;
  ls_ctrl_e          r_ctrl;
  logic              r_we;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;

  logic              w_start;
  logic              w_misalign;
  ls_ctrl_e          w_ctrl_in;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata_rep;
  logic [31:0]       w_rdata_ext;

  assign w_start   = memread_m | memwrite_m;
  assign w_ctrl_in = ls_ctrl_e'(ls_ctrl_m);

  // Store lanes are computed from the live inputs and registered at issue so the
  // request is driven straight from flops; load lanes use the latched address.
  lsu_lane_align u_align (
    .i_st_addr (addr_m[1:0]),
    .i_st_ctrl (w_ctrl_in),
    .i_wdata   (wdata_m),
    .i_ld_addr (r_addr[1:0]),
    .i_ld_ctrl (r_ctrl),
    .i_rdata   (mem_rdata),
    .o_be      (w_be),
    .o_wdata   (w_wdata_rep),
    .o_rdata   (w_rdata_ext)
  );

`ifdef LSU_MISALIGN_EN
  logic r_misalign;

  assign w_misalign = ((w_ctrl_in == LS_WORD) && (addr_m[1:0] != 2'b00)) ||
                      ((w_ctrl_in == LS_HALF) && addr_m[0]);

  // High only during the DONE cycle that follows a trapped access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= (r_state == ST_IDLE) && w_start && w_misalign;
    end
  end

  assign misalign_o = r_misalign;
`else
  assign w_misalign = 1'b0;
  assign misalign_o = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_ctrl  <= LS_WORD;
      r_we    <= 1'b0;
      r_be    <= 4'h0;
      r_wdata <= 32'h0;
      r_rdata <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_addr  <= addr_m;
            r_ctrl  <= w_ctrl_in;
            r_we    <= memwrite_m;
            r_be    <= w_be;
            r_wdata <= w_wdata_rep;
            r_state <= w_misalign ? ST_DONE : ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_gnt) begin
            r_state <= r_we ? ST_DONE : ST_RESP;
          end
        end
        ST_RESP: begin
          if (mem_rvalid) begin
            r_rdata <= w_rdata_ext;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // The pipeline advances this cycle; the next access is seen back in IDLE.
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Reset gates stall combinationally so the pipeline is never frozen while held in reset.
  assign stall_o = ~reset & (((r_state == ST_IDLE) & w_start) |
                             (r_state == ST_REQ) | (r_state == ST_RESP));

  assign mem_req   = (r_state == ST_REQ);
  assign mem_we    = r_we;
  assign mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
  assign mem_be    = r_be;
  assign mem_wdata = r_wdata;
  assign rdata_o   = r_rdata;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: scoreboard of expected access results, checked at each DONE cycle.
// Latency: n/a.
// Backpressure: bench models the memory with programmable gnt and rvalid wait cycles.
module tb_mem_lsu;

  logic        clk;
  logic        reset;
  logic        memread_m;
  logic        memwrite_m;
  logic [1:0]  ls_ctrl_m;
  logic [31:0] addr_m;
  logic [31:0] wdata_m;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        misalign_o;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rd;
    int          stalls;
    bit          mis;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_rd;

  mem_lsu #(.ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .memread_m  (memread_m),
    .memwrite_m (memwrite_m),
    .ls_ctrl_m  (ls_ctrl_m),
    .addr_m     (addr_m),
    .wdata_m    (wdata_m),
    .stall_o    (stall_o),
    .rdata_o    (rdata_o),
    .misalign_o (misalign_o),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] want);
    vec_cnt++;
    if (act !== want) begin
      err_cnt++;
      $display("FAIL %s: got %08h, expected %08h", tag, act, want);
    end
  endtask

  // Reference model of lane behaviour.
  function automatic logic [3:0] m_be(input logic [1:0] c, input logic [1:0] a);
    if (c == 2'b00) return 4'hF;
    if (c == 2'b01) return a[1] ? 4'hC : 4'h3;
    case (a)
      2'd0:    return 4'h1;
      2'd1:    return 4'h2;
      2'd2:    return 4'h4;
      default: return 4'h8;
    endcase
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] c, input logic [31:0] w);
    if (c == 2'b00) return w;
    if (c == 2'b01) return {w[15:0], w[15:0]};
    return {w[7:0], w[7:0], w[7:0], w[7:0]};
  endfunction

  function automatic logic [31:0] m_rd(input logic [1:0] c, input logic [1:0] a, input logic [31:0] w);
    logic [31:0] s;
    if (c == 2'b00) return w;
    if (c == 2'b01) begin
      s = a[1] ? (w >> 16) : w;
      return s[15] ? (s | 32'hFFFF_0000) : (s & 32'h0000_FFFF);
    end
    s = w >> (8 * int'(a));
    if (c == 2'b10 && s[7]) return s | 32'hFFFF_FF00;
    return s & 32'h0000_00FF;
  endfunction

  // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 of the cycle after DONE
  // with the access still presented, so a following call is a back-to-back access.
  task automatic access(input bit wr, input logic [1:0] ctrl, input logic [31:0] addr,
                        input logic [31:0] wd, input int gdly, input int rdly,
                        input logic [31:0] word);
    exp_t e;
    exp_t got;
    int   stalls    = 0;
    int   reqc      = 0;
    int   rvc       = 0;
    int   first_req = -1;
    bit   granted   = 0;
    bit   done      = 0;
    bit   mis       = 0;
`ifdef LSU_MISALIGN_EN
    mis = ((ctrl == 2'b00) && (addr[1:0] != 2'b00)) || ((ctrl == 2'b01) && addr[0]);
`endif
    e.addr   = {addr[31:2], 2'b00};
    e.be     = m_be(ctrl, addr[1:0]);
    e.wd     = m_wd(ctrl, wd);
    e.rd     = (wr || mis) ? last_rd : m_rd(ctrl, addr[1:0], word);
    e.stalls = mis ? 1 : (wr ? 2 + gdly : 3 + gdly + rdly);
    e.mis    = mis;
    last_rd  = e.rd;
    sb.push_back(e);

    memread_m  = !wr;
    memwrite_m = wr;
    ls_ctrl_m  = ctrl;
    addr_m     = addr;
    wdata_m    = wd;
    for (int c = 0; c < 64 && !done; c++) begin
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (mem_req) begin
        if (first_req < 0) first_req = c;
        check("req_addr", mem_addr, e.addr);
        check("req_be", 32'(mem_be), 32'(e.be));
        check("req_we", 32'(mem_we), 32'(wr));
        if (wr) check("req_wdata", mem_wdata, e.wd);
        if (reqc == gdly) begin
          mem_gnt = 1'b1;
          granted = 1'b1;
        end
        reqc++;
      end else if (granted && !wr) begin
        if (rvc == rdly) begin
          mem_rvalid = 1'b1;
          mem_rdata  = word;
        end
        rvc++;
      end
      #1;
      if (stall_o) begin
        stalls++;
      end else begin
        done = 1'b1;
        got  = sb.pop_front();
        check("done_rdata", rdata_o, got.rd);
        check("stall_cycles", 32'(stalls), 32'(got.stalls));
        check("misalign", 32'(misalign_o), 32'(got.mis));
        check("first_req_cycle", 32'(first_req), got.mis ? 32'hFFFF_FFFF : 32'd1);
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("timeout", 32'd0, 32'd1);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  task automatic idle_cycle();
    memread_m  = 1'b0;
    memwrite_m = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    memread_m  = 1'b1;
    memwrite_m = 1'b0;
    ls_ctrl_m  = 2'b00;
    addr_m     = 32'h0;
    wdata_m    = 32'h0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    last_rd    = 32'h0;

    repeat (2) @(posedge clk);
    #2;
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_misalign", 32'(misalign_o), 32'd0);
    check("rst_be", 32'(mem_be), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    memread_m = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    access(0, 2'b00, 32'h10, 32'h0, 0, 0, 32'hDEADBEEF);
    idle_cycle();
    access(0, 2'b01, 32'h12, 32'h0, 0, 0, 32'h8001_1234);
    access(0, 2'b11, 32'h13, 32'h0, 0, 0, 32'h8001_1234);
    access(0, 2'b10, 32'h13, 32'h0, 1, 0, 32'h8001_1234);
    idle_cycle();
    access(1, 2'b10, 32'h21, 32'h0000_00A5, 3, 0, 32'h0);
    idle_cycle();
    // Delayed rvalid load followed directly by a store.
    access(0, 2'b01, 32'h10, 32'h0, 0, 2, 32'h7FFF_0055);
    access(1, 2'b01, 32'h16, 32'h1234_BEEF, 0, 0, 32'h0);
    access(1, 2'b00, 32'h2C, 32'hCAFE_F00D, 1, 0, 32'h0);
    access(0, 2'b10, 32'h01, 32'h0, 0, 1, 32'h1122_F344);
    idle_cycle();

    for (int i = 0; i < 10; i++) begin
      access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             {24'h0, 8'($urandom_range(0, 255))}, $urandom,
             $urandom_range(0, 2), $urandom_range(0, 2), $urandom);
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    idle_cycle();

    // Misaligned word load: trapped when the check is built in, truncated to 0x20 otherwise.
    access(0, 2'b00, 32'h30, 32'h0, 0, 0, 32'h0BAD_F00D);
    access(0, 2'b00, 32'h22, 32'h0, 0, 0, 32'h5A5A_1234);
    idle_cycle();

    // Reset while waiting for the load response.
    memread_m = 1'b1;
    ls_ctrl_m = 2'b00;
    addr_m    = 32'h40;
    @(posedge clk);
    #1;
    check("rr_req_before", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    @(posedge clk);
    #1;
    mem_gnt   = 1'b0;
    memread_m = 1'b0;
    reset     = 1'b1;
    #1;
    check("rr_stall_in_reset", 32'(stall_o), 32'd0);
    check("rr_req_in_reset", 32'(mem_req), 32'd0);
    check("rr_rdata_cleared", rdata_o, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_5678;
    #1;
    check("rr_late_stall", 32'(stall_o), 32'd0);
    @(posedge clk);
    #1;
    mem_rvalid = 1'b0;
    #1;
    check("rr_late_rdata", rdata_o, 32'd0);
    check("rr_late_req", 32'(mem_req), 32'd0);
    last_rd = 32'h0;
    @(posedge clk);
    #1;

    // Reset while the request is waiting for grant: mem_req must drop at once.
    memwrite_m = 1'b1;
    ls_ctrl_m  = 2'b00;
    addr_m     = 32'h48;
    wdata_m    = 32'h1111_2222;
    @(posedge clk);
    #1;
    check("rq_req_before", 32'(mem_req), 32'd1);
    memwrite_m = 1'b0;
    reset      = 1'b1;
    #1;
    check("rq_req_in_reset", 32'(mem_req), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    access(0, 2'b11, 32'h46, 32'h0, 0, 0, 32'h00C3_0000);
    idle_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
